// File: rtl/pwl_euler_sched_if.sv
// Command/result bundle for the PWL jerk-system Euler sequencer.
// master drives start/iters; slave returns busy, strobes, step count and state.
interface pwl_euler_sched_if #(
    parameter int W = 16
);
    logic                start;
    logic [15:0]         iters;
    logic                busy;
    logic                valid;
    logic                done;
    logic [15:0]         step_cnt;
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] z;

    modport master (output start, iters, input busy, valid, done, step_cnt, x, y, z);
    modport slave  (input start, iters, output busy, valid, done, step_cnt, x, y, z);
endinterface

// File: rtl/pwl_euler_sched.sv
// Time-multiplexed explicit-Euler sequencer for x'=y, y'=z, z'=-A*z - y + |x| - 1 (Q3.13).
// Define PWL_EULER_SAT_EN to saturate products and sums; otherwise they wrap modulo 2^W.
module pwl_euler_sched #(
    parameter int                  W      = 16,
    parameter int                  FRAC   = 13,
    parameter logic signed [W-1:0] A_COEF = 16'sd4915,
    parameter logic signed [W-1:0] H_STEP = 16'sd410,
    parameter logic signed [W-1:0] X0     = 16'sd0,
    parameter logic signed [W-1:0] Y0     = 16'sd0,
    parameter logic signed [W-1:0] Z0     = 16'sd0
) (
    input logic               clk,
    input logic               rst,
    pwl_euler_sched_if.slave  bus
);
    localparam int W2 = 2 * W;
    localparam logic signed [W-1:0]  SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W2-1:0] ONE  = W2'(1) <<< FRAC;
`ifdef PWL_EULER_SAT_EN
    localparam logic signed [W2-1:0] MAXV = W2'(SMAX);
    localparam logic signed [W2-1:0] MINV = W2'(SMIN);
`endif

    typedef enum logic [2:0] {IDLE, LOAD, M_AZ, M_HX, M_HY, M_HZ, UPD} state_t;

    state_t              state, state_nx;
    logic [15:0]         iters_q, cnt_r;
    logic                busy_r, valid_r, done_r;
    logic signed [W-1:0] x_r, y_r, z_r;
    logic signed [W-1:0] p, dz, q_x, q_y, q_z;
    logic signed [W-1:0] mul_a, mul_b;
    logic                ld_init, upd, fin;
    logic signed [W2-1:0] prod, sh;
    logic signed [W-1:0] prod_r, abs_x, dz_n, x_n, y_n, z_n;

    function automatic logic signed [W-1:0] red(input logic signed [W2-1:0] v);
`ifdef PWL_EULER_SAT_EN
        if (v > MAXV) return SMAX;
        if (v < MINV) return SMIN;
        return W'(v);
`else
        return W'(v);
`endif
    endfunction

    // Single shared multiplier; the FSM steers its operands each cycle.
    assign prod   = W2'(mul_a) * W2'(mul_b);
    assign sh     = prod >>> FRAC;
    assign prod_r = red(sh);

    // |min| has no positive twin, so it is pinned to the largest positive value.
    assign abs_x = (x_r == SMIN) ? SMAX : (x_r[W-1] ? -x_r : x_r);
    assign dz_n  = red(-W2'(p) - W2'(y_r) + W2'(abs_x) - ONE);
    assign x_n   = red(W2'(x_r) + W2'(q_x));
    assign y_n   = red(W2'(y_r) + W2'(q_y));
    assign z_n   = red(W2'(z_r) + W2'(q_z));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ld_init  = 1'b0;
        upd      = 1'b0;
        fin      = 1'b0;
        mul_a    = H_STEP;
        mul_b    = z_r;
        case (state)
            IDLE: if (bus.start) state_nx = LOAD;
            LOAD: begin
                ld_init = 1'b1;
                if (iters_q == 16'd0) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = M_AZ;
                end
            end
            M_AZ: begin
                mul_a    = A_COEF;
                state_nx = M_HX;
            end
            M_HX: begin
                mul_b    = y_r;
                state_nx = M_HY;
            end
            M_HY: state_nx = M_HZ;
            M_HZ: begin
                mul_b    = dz;
                state_nx = UPD;
            end
            UPD: begin
                upd = 1'b1;
                if (cnt_r + 16'd1 == iters_q) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = M_AZ;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            iters_q <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            p       <= '0;
            dz      <= '0;
            q_x     <= '0;
            q_y     <= '0;
            q_z     <= '0;
        end else begin
            valid_r <= upd;
            done_r  <= fin;
            if (state == IDLE && bus.start) begin
                iters_q <= bus.iters;
                busy_r  <= 1'b1;
            end
            if (fin) busy_r <= 1'b0;
            if (ld_init) begin
                x_r   <= X0;
                y_r   <= Y0;
                z_r   <= Z0;
                cnt_r <= '0;
            end
            // Products land in scratch registers; x/y/z move only in UPD.
            case (state)
                M_AZ: p <= prod_r;
                M_HX: begin
                    dz  <= dz_n;
                    q_x <= prod_r;
                end
                M_HY: q_y <= prod_r;
                M_HZ: q_z <= prod_r;
                UPD: begin
                    x_r   <= x_n;
                    y_r   <= y_n;
                    z_r   <= z_n;
                    cnt_r <= cnt_r + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.valid    = valid_r;
    assign bus.done     = done_r;
    assign bus.step_cnt = cnt_r;
    assign bus.x        = x_r;
    assign bus.y        = y_r;
    assign bus.z        = z_r;
endmodule

// File: tb/tb_pwl_euler_sched.sv
// Scoreboard bench: an integer Euler model queues expected strobes, monitors pop on valid/done.
module tb_pwl_euler_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwl_euler_sched_if #(.W(16)) bus0 ();
    pwl_euler_sched_if #(.W(16)) bus1 ();

    pwl_euler_sched u_dut (.clk(clk), .rst(rst), .bus(bus0));
    pwl_euler_sched #(.H_STEP(16'sd8192), .Y0(16'sd30000), .Z0(16'sd8192))
        u_sat (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        int x, y, z, cnt;
        bit last, has_v;
        int cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // cyc counts edges; a strobe registered at edge N is seen at the following negedge with cyc==N.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fit(input int v);
`ifdef PWL_EULER_SAT_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        int r;
        r = v % 65536;
        if (r > 32767) r -= 65536;
        if (r < -32768) r += 65536;
        return r;
`endif
    endfunction

    function automatic int mulq(input int a, input int b);
        longint pr, qt;
        pr = longint'(a) * longint'(b);
        qt = pr / 8192;
        if (pr < 0 && (pr % 8192) != 0) qt = qt - 1;
        return fit(int'(qt));
    endfunction

    function automatic int absq(input int v);
        if (v == -32768) return 32767;
        return (v < 0) ? -v : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int id, input exp_t e);
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    // s = edge index at which start is sampled.
    task automatic model(input int id, input int n, input int s);
        int a, h, x, y, z, dz, nx, ny, nz;
        exp_t e;
        a = 4915;
        h = (id == 0) ? 410 : 8192;
        x = 0;
        y = (id == 0) ? 0 : 30000;
        z = (id == 0) ? 0 : 8192;
        if (n == 0) begin
            e.x = x; e.y = y; e.z = z; e.cnt = 0;
            e.last = 1'b1; e.has_v = 1'b0; e.cyc = s + 1;
            push(id, e);
            return;
        end
        for (int k = 1; k <= n; k++) begin
            dz = fit(-mulq(a, z) - y + absq(x) - 8192);
            nx = fit(x + mulq(h, y));
            ny = fit(y + mulq(h, z));
            nz = fit(z + mulq(h, dz));
            x = nx; y = ny; z = nz;
            e.x = x; e.y = y; e.z = z; e.cnt = k;
            e.last = (k == n); e.has_v = 1'b1;
            e.cyc = s + 6 + 5 * (k - 1);
            push(id, e);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic d, input logic b,
                       input int cnt, input int xv, input int yv, input int zv);
        exp_t e;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL spurious_strobe dut%0d valid=%0b done=%0b expected none", id, v, d);
            return;
        end
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("valid_d%0d_s%0d", id, e.cnt), int'(v), int'(e.has_v));
        chk($sformatf("done_d%0d_s%0d", id, e.cnt), int'(d), int'(e.last));
        chk($sformatf("busy_d%0d_s%0d", id, e.cnt), int'(b), e.last ? 0 : 1);
        chk($sformatf("timing_d%0d_s%0d", id, e.cnt), cyc, e.cyc);
        chk($sformatf("step_cnt_d%0d_s%0d", id, e.cnt), cnt, e.cnt);
        chk($sformatf("x_d%0d_s%0d", id, e.cnt), xv, e.x);
        chk($sformatf("y_d%0d_s%0d", id, e.cnt), yv, e.y);
        chk($sformatf("z_d%0d_s%0d", id, e.cnt), zv, e.z);
    endtask

    always @(negedge clk)
        if (rst && (bus0.valid || bus0.done))
            mon(0, bus0.valid, bus0.done, bus0.busy, bus0.step_cnt, bus0.x, bus0.y, bus0.z);

    always @(negedge clk)
        if (rst && (bus1.valid || bus1.done))
            mon(1, bus1.valid, bus1.done, bus1.busy, bus1.step_cnt, bus1.x, bus1.y, bus1.z);

    task automatic run(input int id, input int n);
        @(negedge clk);
        if (id == 0) begin bus0.start = 1'b1; bus0.iters = 16'(n); end
        else         begin bus1.start = 1'b1; bus1.iters = 16'(n); end
        model(id, n, cyc + 1);
        @(negedge clk);
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        chk($sformatf("busy_after_start_d%0d", id), int'(id == 0 ? bus0.busy : bus1.busy), 1);
    endtask

    task automatic wait_idle(input int id, input int budget);
        for (int i = 0; i < budget; i++) begin
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL run_timeout dut%0d pending=%0d expected 0", id,
                 id == 0 ? q0.size() : q1.size());
        q0.delete();
        q1.delete();
    endtask

    task automatic wait_cnt(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus0.step_cnt == 16'(n)) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_step_cnt actual=%0d expected=%0d", bus0.step_cnt, n);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(bus0.busy), 0);
        chk({tag, "_valid"}, int'(bus0.valid), 0);
        chk({tag, "_done"}, int'(bus0.done), 0);
        chk({tag, "_step_cnt"}, int'(bus0.step_cnt), 0);
        chk({tag, "_x"}, int'(bus0.x), 0);
        chk({tag, "_y"}, int'(bus0.y), 0);
        chk({tag, "_z"}, int'(bus0.z), 0);
    endtask

    initial begin
        int n, gap;
        rst = 1'b0;
        bus0.start = 1'b0; bus0.iters = '0;
        bus1.start = 1'b0; bus1.iters = '0;
        repeat (2) @(negedge clk);
        bus0.start = 1'b1; bus0.iters = 16'd5;
        @(negedge clk);
        bus0.start = 1'b0;
        chk_zero("reset");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset_busy", int'(bus0.busy), 0);

        run(0, 1);
        wait_idle(0, 40);
        chk("iters1_x", int'(bus0.x), 0);
        chk("iters1_y", int'(bus0.y), 0);
        chk("iters1_z", int'(bus0.z), -410);
        @(negedge clk);
        chk("iters1_busy_after", int'(bus0.busy), 0);

        run(0, 3);
        wait_idle(0, 60);
        chk("iters3_step_cnt", int'(bus0.step_cnt), 3);

        run(0, 0);
        wait_idle(0, 20);
        chk("iters0_x", int'(bus0.x), 0);

        run(1, 1);
        wait_idle(1, 40);
        chk("sat_x", int'(bus1.x), 30000);
`ifdef PWL_EULER_SAT_EN
        chk("sat_y", int'(bus1.y), 32767);
`else
        chk("wrap_y", int'(bus1.y), -27344);
`endif

        // A start during a run must not relatch iters.
        run(0, 10);
        wait_cnt(4, 80);
        #1 bus0.start = 1'b1; bus0.iters = 16'd1;
        @(negedge clk);
        bus0.start = 1'b0;
        wait_idle(0, 120);

        // Reset mid-run abandons it without done.
        run(0, 10);
        wait_cnt(5, 80);
        #1;
        q0.delete();
        rst = 1'b0;
        @(negedge clk);
        chk_zero("abort");
        rst = 1'b1;
        repeat (4) @(negedge clk);
        run(0, 2);
        wait_idle(0, 40);

        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, 8);
            run(0, n);
            if (n > 1 && $urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 5 * n)) @(negedge clk);
                if (bus0.busy) begin
                    bus0.start = 1'b1;
                    bus0.iters = 16'($urandom_range(0, 65535));
                    @(negedge clk);
                    bus0.start = 1'b0;
                end
            end
            wait_idle(0, 5 * n + 20);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end

        repeat (8) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
